// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port and single-memory port around the unified memory arbiter.
// The slave view is the arbiter. The master view is its environment, which is the mips core on the
// fetch/data side and the memory on the mem side.
interface unified_mem_arbiter_if;
  // Fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_stall;
  // Data port
  logic        d_req;
  logic        d_rd_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_stall;
  // Memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [1:0]  mem_access_size;
  logic        mem_rd_wr;
  logic        mem_enable;

  modport slave (
    input  i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, d_size, mem_dout,
    output i_gnt, i_rvalid, i_rdata, i_stall, d_gnt, d_rvalid, d_rdata, d_stall,
    output mem_addr, mem_din, mem_access_size, mem_rd_wr, mem_enable
  );

  modport master (
    output i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, d_size, mem_dout,
    input  i_gnt, i_rvalid, i_rdata, i_stall, d_gnt, d_rvalid, d_rdata, d_stall,
    input  mem_addr, mem_din, mem_access_size, mem_rd_wr, mem_enable
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous memory between the mips fetch and data ports.
// At most one access is granted per cycle. The data port wins contention. A starvation counter
// forces fetch ahead once it has been denied STARVE_LIMIT consecutive cycles. Read data returns
// one cycle after the grant, to whichever port owned the previous cycle's read.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 4
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);

  localparam logic [1:0]       SZ_WORD = 2'b10;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             i_req_v, d_req_v, force_i, i_gnt, d_gnt;

  // Grant decision. Requests are masked while reset is held, so no grant or stall leaks out.
  always_comb begin
    i_req_v = bus.i_req & ~reset;
    d_req_v = bus.d_req & ~reset;
    force_i = (starve_cnt_q == LIMIT);
    d_gnt   = d_req_v & ~(i_req_v & force_i);
    i_gnt   = i_req_v & ~d_gnt;
  end

  // Steer the granted port onto the memory. An idle cycle drives the reset values.
  always_comb begin
    bus.mem_enable      = 1'b0;
    bus.mem_rd_wr       = 1'b1;
    bus.mem_addr        = '0;
    bus.mem_din         = '0;
    bus.mem_access_size = SZ_WORD;
    if (i_gnt) begin
      bus.mem_enable = 1'b1;
      bus.mem_addr   = bus.i_addr;
    end else if (d_gnt) begin
      bus.mem_enable      = 1'b1;
      bus.mem_rd_wr       = bus.d_rd_wr;
      bus.mem_addr        = bus.d_addr;
      bus.mem_din         = bus.d_wdata;
      bus.mem_access_size = bus.d_size;
    end
  end

  // Owner of the read now in flight, plus the next starvation count.
  always_comb begin
    owner_d = OwnNone;
    if (i_gnt) begin
      owner_d = OwnI;
    end else if (d_gnt && bus.d_rd_wr) begin
      owner_d = OwnD;
    end

    starve_cnt_d = starve_cnt_q;
    if (i_gnt || !i_req_v) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // State register. Reset drops any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OwnNone;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_stall  = i_req_v & ~i_gnt;
  assign bus.d_stall  = d_req_v & ~d_gnt;
  assign bus.i_rvalid = (owner_q == OwnI);
  assign bus.d_rvalid = (owner_q == OwnD);
  assign bus.i_rdata  = bus.mem_dout;
  assign bus.d_rdata  = bus.mem_dout;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter (STARVE_LIMIT=3).
// Read grants push the expected data onto a per-port queue. A negedge monitor pops one entry
// when the matching rvalid is due, and it requires rvalid low when nothing is outstanding.
module tb_unified_mem_arbiter;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [31:0] BASE    = 32'h8002_0000;
  localparam logic [31:0] DADDR   = 32'h8002_0100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] fetch_words [4];
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  logic [31:0] mem_model [logic [31:0]];

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(
    .STARVE_LIMIT(3),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory: a read returns data the cycle after enable, a write commits at the edge.
  initial begin : mem_proc
    logic [31:0] wa;
    logic [31:0] w;
    bus.mem_dout = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_enable === 1'b1) begin
        wa = {bus.mem_addr[31:2], 2'b00};
        w  = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
        if (bus.mem_rd_wr) begin
          bus.mem_dout = w;
        end else begin
          case (bus.mem_access_size)
            2'b00:   w[8*bus.mem_addr[1:0] +: 8] = bus.mem_din[7:0];
            2'b01:   w[16*bus.mem_addr[1] +: 16] = bus.mem_din[15:0];
            default: w = bus.mem_din;
          endcase
          mem_model[wa] = w;
        end
      end
    end
  end

  // Response scoreboard.
  initial begin : monitor
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (iq.size() > 0) begin
          exp = iq.pop_front();
          if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== exp) begin
            errors++;
            $display("FAIL i_resp got rvalid=%b data=%h want rvalid=1 data=%h",
                     bus.i_rvalid, bus.i_rdata, exp);
          end
        end else if (bus.i_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL i_rvalid_idle got %b want 0", bus.i_rvalid);
        end
        checks++;
        if (dq.size() > 0) begin
          exp = dq.pop_front();
          if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp) begin
            errors++;
            $display("FAIL d_resp got rvalid=%b data=%h want rvalid=1 data=%h",
                     bus.d_rvalid, bus.d_rdata, exp);
          end
        end else if (bus.d_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL d_rvalid_idle got %b want 0", bus.d_rvalid);
        end
      end
    end
  end

  // Apply one cycle of stimulus just after the falling edge.
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic rw,
                       input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sz);
    @(negedge clk);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_rd_wr = rw;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.d_size  = sz;
    #1;
  endtask

  task automatic test_reset();
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_rd_wr = 1'b1;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = SZ_WORD;
    #2;
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_stall, bus.d_stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_stall, bus.d_stall});
    end
    checks++;
    if (bus.mem_enable !== 1'b0 || bus.mem_rd_wr !== 1'b1) begin
      errors++;
      $display("FAIL reset_mem_ctl got en=%b rw=%b want en=0 rw=1", bus.mem_enable, bus.mem_rd_wr);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_din !== 32'h0 || bus.mem_access_size !== SZ_WORD) begin
      errors++;
      $display("FAIL reset_mem_bus got addr=%h din=%h sz=%b want 0/0/%b",
               bus.mem_addr, bus.mem_din, bus.mem_access_size, SZ_WORD);
    end
    checks++;
    if (dut.starve_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", dut.starve_cnt_q);
    end
    // A request made while reset is held must not be granted or stalled.
    bus.i_req = 1'b1;
    #1;
    checks++;
    if (bus.i_gnt !== 1'b0 || bus.i_stall !== 1'b0 || bus.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_masked got gnt=%b stall=%b en=%b want 0/0/0",
               bus.i_gnt, bus.i_stall, bus.mem_enable);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, BASE, 1'b0, 1'b1, '0, '0, SZ_WORD);
    checks++;
    if (bus.i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_gnt got %b want 1", bus.i_gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.i_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_rvalid got %b want 1", bus.i_rvalid);
    end
    // Reset lands in the middle of the read's response cycle.
    reset = 1'b1;
    #1;
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.mem_enable !== 1'b0 || dut.starve_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_read got rvalid=%b en=%b cnt=%0d want 0/0/0",
               bus.i_rvalid, bus.mem_enable, dut.starve_cnt_q);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dropped got i=%b d=%b want 0/0", bus.i_rvalid, bus.d_rvalid);
    end
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, BASE + 32'(4 * k), 1'b0, 1'b1, '0, '0, SZ_WORD);
      checks++;
      if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.i_stall !== 1'b0) begin
        errors++;
        $display("FAIL fetch_gnt[%0d] got i=%b d=%b stall=%b want 1/0/0",
                 k, bus.i_gnt, bus.d_gnt, bus.i_stall);
      end
      checks++;
      if (bus.mem_addr !== BASE + 32'(4 * k) || bus.mem_rd_wr !== 1'b1 ||
          bus.mem_access_size !== SZ_WORD || bus.mem_enable !== 1'b1) begin
        errors++;
        $display("FAIL fetch_mem[%0d] got addr=%h rw=%b sz=%b en=%b want %h/1/%b/1", k,
                 bus.mem_addr, bus.mem_rd_wr, bus.mem_access_size, bus.mem_enable,
                 BASE + 32'(4 * k), SZ_WORD);
      end
      iq.push_back(fetch_words[k]);
    end
    drive(1'b0, '0, 1'b0, 1'b1, '0, '0, SZ_WORD);
  endtask

  task automatic test_store_load();
    drive(1'b0, '0, 1'b1, 1'b0, DADDR, 32'hDEAD_BEEF, SZ_WORD);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_rd_wr !== 1'b0 || bus.mem_din !== 32'hDEAD_BEEF ||
        bus.mem_addr !== DADDR) begin
      errors++;
      $display("FAIL store_grant got gnt=%b rw=%b din=%h addr=%h want 1/0/deadbeef/%h",
               bus.d_gnt, bus.mem_rd_wr, bus.mem_din, bus.mem_addr, DADDR);
    end
    drive(1'b0, '0, 1'b1, 1'b1, DADDR, '0, SZ_WORD);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_rd_wr !== 1'b1) begin
      errors++;
      $display("FAIL load_grant got gnt=%b rw=%b want 1/1", bus.d_gnt, bus.mem_rd_wr);
    end
    dq.push_back(32'hDEAD_BEEF);
    drive(1'b0, '0, 1'b0, 1'b1, '0, '0, SZ_WORD);
  endtask

  // Both ports contend per the table. ireq_tab lets fetch drop out for a cycle.
  task automatic test_contention(input string name, input int n, input logic [15:0] ireq_tab,
                                 input logic [15:0] igrant_tab);
    for (int c = 0; c < n; c++) begin
      drive(ireq_tab[c], BASE, 1'b1, 1'b1, DADDR, '0, SZ_WORD);
      checks++;
      if (bus.i_gnt !== igrant_tab[c] || bus.d_gnt !== ~igrant_tab[c] ||
          bus.i_stall !== (ireq_tab[c] & ~igrant_tab[c]) || bus.d_stall !== igrant_tab[c]) begin
        errors++;
        $display("FAIL %s[%0d] got ig=%b dg=%b is=%b ds=%b want ig=%b", name, c,
                 bus.i_gnt, bus.d_gnt, bus.i_stall, bus.d_stall, igrant_tab[c]);
      end
      if (igrant_tab[c]) iq.push_back(fetch_words[0]);
      else               dq.push_back(32'hDEAD_BEEF);
    end
    drive(1'b0, '0, 1'b0, 1'b1, '0, '0, SZ_WORD);
  endtask

  task automatic test_write_grant();
    drive(1'b0, '0, 1'b1, 1'b0, 32'h8002_0200, 32'h1234_5678, SZ_WORD);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL write_gnt got gnt=%b en=%b want 1/1", bus.d_gnt, bus.mem_enable);
    end
    drive(1'b0, '0, 1'b0, 1'b1, '0, '0, SZ_WORD);
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rvalid got i=%b d=%b want 0/0", bus.i_rvalid, bus.d_rvalid);
    end
  endtask

  task automatic test_byte_store();
    drive(1'b0, '0, 1'b1, 1'b0, 32'h8002_0003, 32'h0000_00AB, SZ_BYTE);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_access_size !== SZ_BYTE || bus.mem_din !== 32'h0000_00AB ||
        bus.mem_addr !== 32'h8002_0003 || bus.mem_rd_wr !== 1'b0) begin
      errors++;
      $display("FAIL byte_store got gnt=%b sz=%b din=%h addr=%h rw=%b want 1/%b/000000ab/80020003/0",
               bus.d_gnt, bus.mem_access_size, bus.mem_din, bus.mem_addr, bus.mem_rd_wr, SZ_BYTE);
    end
    drive(1'b0, '0, 1'b0, 1'b1, '0, '0, SZ_WORD);
  endtask

  initial begin
    fetch_words[0] = 32'h2408_0001;
    fetch_words[1] = 32'h2409_0002;
    fetch_words[2] = 32'h0109_5020;
    fetch_words[3] = 32'hAC0A_0100;
    for (int k = 0; k < 4; k++) mem_model[BASE + 32'(4 * k)] = fetch_words[k];

    test_reset();
    mon_en = 1'b1;
    test_fetch_only();
    test_store_load();
    // D,D,D,I,D,D,D,I (bit c = cycle c)
    test_contention("contend", 8, 16'h00FF, 16'h0088);
    // D,D, fetch drops (D), then D,D,D,I: the denied cycles before the drop are forgotten
    test_contention("drop", 7, 16'h007B, 16'h0040);
    test_write_grant();
    test_byte_store();
    drive(1'b0, '0, 1'b0, 1'b1, '0, '0, SZ_WORD);

    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain got iq=%0d dq=%0d want 0/0", iq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
